// File: rtl/capiano_cam_pkg.sv
// Canvas geometry and address layout shared by the camera canvas writer and its readers.
package capiano_cam_pkg;

  localparam int CANVAS_COLS = 160;
  localparam int CANVAS_ROWS = 120;

  localparam int ROW_LSB = 18;
  localparam int ROW_W   = 7;
  localparam int COL_LSB = 2;
  localparam int COL_W   = 8;

  localparam int PIX_W   = 9;
  localparam int FIELD_W = 3;
  localparam int SUM_W   = 5;

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_SCAN  = 2'd1,
    KS_DRAIN = 2'd2
  } ks_state_e;

  function automatic logic [31:0] canvas_addr(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
    logic [31:0] a;
    a = '0;
    a[ROW_LSB +: ROW_W] = row;
    a[COL_LSB +: COL_W] = col;
    return a;
  endfunction

endpackage

// File: rtl/pixel_hit.sv
// Classifies one canvas pixel: the three brightness fields summed against a threshold.
module pixel_hit
  import capiano_cam_pkg::*;
(
  input  logic [PIX_W-1:0] q_i,
  input  logic [SUM_W-1:0] thresh_i,
  output logic             hit_o
);

  logic [SUM_W-1:0] sum;

  assign sum   = SUM_W'(q_i[2*FIELD_W +: FIELD_W]) +
                 SUM_W'(q_i[FIELD_W +: FIELD_W]) +
                 SUM_W'(q_i[0 +: FIELD_W]);
  assign hit_o = (sum >= thresh_i);

endmodule

// File: rtl/key_scanner.sv
// Scans the key band of the canvas strip by strip and publishes a pressed-key mask per scan.
module key_scanner
  import capiano_cam_pkg::*;
#(
  parameter int NUM_KEYS   = 8,
  parameter int KEY_W      = 20,
  parameter int ROW_START  = 60,
  parameter int ROW_END    = 89,
  parameter int PIX_THRESH = 9,
  parameter int HIT_MIN    = 120,
  parameter int CNT_W      = 12
) (
  input  logic                mem_clk,
  input  logic                rst,
  input  logic                start,
  output logic [31:0]         addr,
  input  logic [PIX_W-1:0]    q,
  output logic                busy,
  output logic                done,
  output logic [NUM_KEYS-1:0] key_mask
);

  localparam int KEY_IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(ROW_START);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_END);
  localparam logic [COL_W-1:0]  OFF_LAST  = COL_W'(KEY_W - 1);
  localparam logic [COL_W-1:0]  STRIDE    = COL_W'(KEY_W);
  localparam logic [KEY_IW-1:0] KEY_LAST  = KEY_IW'(NUM_KEYS - 1);
  localparam logic [CNT_W:0]    HIT_LIM   = (CNT_W+1)'(HIT_MIN);
  localparam logic [SUM_W-1:0]  THRESH    = SUM_W'(PIX_THRESH);

  ks_state_e           state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    off_q, off_d;
  logic [COL_W-1:0]    base_q, base_d;
  logic [KEY_IW-1:0]   key_q, key_d;
  logic [31:0]         addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic [NUM_KEYS-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                vld_p0_q, vld_p0_d, vld_p1_q;
  logic                last_p0_q, last_p0_d, last_p1_q;
  logic [KEY_IW-1:0]   key_p0_q, key_p0_d, key_p1_q;

  logic                hit;
  logic [CNT_W:0]      cnt_sum;
  logic                pix_last_key;
  logic                pix_last_all;

  pixel_hit u_pixel_hit (
    .q_i      (q),
    .thresh_i (THRESH),
    .hit_o    (hit)
  );

  assign pix_last_key = (row_q == ROW_LAST) && (off_q == OFF_LAST);
  assign pix_last_all = pix_last_key && (key_q == KEY_LAST);
  assign cnt_sum      = {1'b0, cnt_q} + (CNT_W+1)'(hit);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    off_d     = off_q;
    base_d    = base_q;
    key_d     = key_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mask_d    = mask_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    vld_p0_d  = 1'b0;
    last_p0_d = 1'b0;
    key_p0_d  = key_q;

    // Stage p1: tag and q describe the same pixel here.
    if (vld_p1_q) begin
      if (last_p1_q) begin
        stage_d[key_p1_q] = (cnt_sum >= HIT_LIM);
        cnt_d             = '0;
      end else begin
        cnt_d = cnt_sum[CNT_W-1:0];
      end
    end

    case (state_q)
      KS_IDLE: begin
        if (start) begin
          state_d  = KS_SCAN;
          busy_d   = 1'b1;
          row_d    = ROW_FIRST;
          off_d    = '0;
          base_d   = '0;
          key_d    = '0;
          vld_p0_d = 1'b1;
        end
      end
      KS_SCAN: begin
        if (pix_last_all) begin
          state_d = KS_DRAIN;
        end else begin
          vld_p0_d = 1'b1;
          if (off_q == OFF_LAST) begin
            off_d = '0;
            if (row_q == ROW_LAST) begin
              row_d  = ROW_FIRST;
              key_d  = key_q + 1'b1;
              base_d = base_q + STRIDE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            off_d = off_q + 1'b1;
          end
        end
      end
      KS_DRAIN: begin
        // The final strip's bit is folded in via stage_d so the mask updates in one step.
        state_d = KS_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        mask_d  = stage_d;
      end
      default: state_d = KS_IDLE;
    endcase

    // Stage p0: tag launched together with the address it describes.
    if (vld_p0_d) begin
      addr_d    = canvas_addr(row_d, base_d + off_d);
      last_p0_d = (row_d == ROW_LAST) && (off_d == OFF_LAST);
      key_p0_d  = key_d;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q   <= KS_IDLE;
      row_q     <= '0;
      off_q     <= '0;
      base_q    <= '0;
      key_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mask_q    <= '0;
      stage_q   <= '0;
      cnt_q     <= '0;
      vld_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      key_p0_q  <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      key_p1_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      off_q     <= off_d;
      base_q    <= base_d;
      key_q     <= key_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mask_q    <= mask_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      vld_p0_q  <= vld_p0_d;
      last_p0_q <= last_p0_d;
      key_p0_q  <= key_p0_d;
      vld_p1_q  <= vld_p0_q;
      last_p1_q <= last_p0_q;
      key_p1_q  <= key_p0_q;
    end
  end

  assign addr     = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign key_mask = mask_q;

endmodule

// File: tb/tb_key_scanner.sv
// Bench for key_scanner: canvas memory with a registered read port, a scan-level model, directed scenarios.
module tb_key_scanner;

  localparam int NK   = 8;
  localparam int KW   = 20;
  localparam int RS   = 60;
  localparam int RE   = 89;
  localparam int NROW = RE - RS + 1;
  localparam int N    = NK * KW * NROW;
  localparam int HMIN = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start3;
  logic [31:0] addr, addr3;
  logic [8:0]  q, q3;
  logic        busy, done, busy3, done3;
  logic [7:0]  key_mask, key_mask3;

  logic [8:0]  mem [0:119][0:159];

  key_scanner dut (
    .mem_clk(clk), .rst(rst), .start(start), .addr(addr), .q(q),
    .busy(busy), .done(done), .key_mask(key_mask)
  );

  key_scanner #(.PIX_THRESH(3)) dut3 (
    .mem_clk(clk), .rst(rst), .start(start3), .addr(addr3), .q(q3),
    .busy(busy3), .done(done3), .key_mask(key_mask3)
  );

  function automatic logic [8:0] rd(input logic [31:0] a);
    int r, c;
    r = int'(a[24:18]);
    c = int'(a[9:2]);
    if (r < 120 && c < 160) return mem[r][c];
    return 9'h0;
  endfunction

  always @(posedge clk) begin
    q  <= rd(addr);
    q3 <= rd(addr3);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, need 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    int k, j, r, c;
    k = i / (KW * NROW);
    j = i % (KW * NROW);
    r = RS + j / KW;
    c = k * KW + j % KW;
    return 32'((r << 18) | (c << 2));
  endfunction

  function automatic logic [7:0] exp_mask(input int thr);
    logic [7:0] m;
    logic [8:0] px;
    int cnt, s;
    m = '0;
    for (int k = 0; k < NK; k++) begin
      cnt = 0;
      for (int r = RS; r <= RE; r++)
        for (int c = k * KW; c < k * KW + KW; c++) begin
          px = mem[r][c];
          s  = int'(px[8:6]) + int'(px[5:3]) + int'(px[2:0]);
          if (s >= thr) cnt++;
        end
      m[k] = (cnt >= HMIN);
    end
    return m;
  endfunction

  task automatic fill(input logic [8:0] v);
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++) mem[r][c] = v;
  endtask

  task automatic fill_strip(input int k, input logic [8:0] v);
    for (int r = RS; r <= RE; r++)
      for (int c = k * KW; c < k * KW + KW; c++) mem[r][c] = v;
  endtask

  // Scan-level model: acceptance, N+1 cycles of busy, then done with the mask of the accepted canvas.
  bit         m_on = 1'b0;
  bit         m_busy, m_done, m_addr_chk;
  logic [7:0] m_mask, m_pend;
  logic [31:0] m_addr;
  int         m_i;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_mask = '0;
      m_addr = '0; m_addr_chk = 1'b1; m_i = 0;
    end else if (m_on) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_i++;
        if (m_i < N) m_addr = addr_of(m_i);
        else m_addr_chk = 1'b0;
        if (m_i == N + 1) begin
          m_done = 1'b1; m_busy = 1'b0; m_mask = m_pend;
        end
      end else if (start) begin
        m_busy = 1'b1; m_i = 0; m_addr = addr_of(0); m_addr_chk = 1'b1;
        m_pend = exp_mask(9);
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("key_mask", 32'(key_mask), 32'(m_mask));
      if (m_addr_chk) chk("addr", addr, m_addr);
    end
  end

  task automatic launch(input bit pin_addr, input bit use3, input bit repulse,
                        input int abort_at, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    if (use3) start3 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat <= N + 10) begin
      bcnt += int'(busy);
      if (pin_addr && lat == 0) chk("first_addr", addr, 32'h00F00000);
      if (pin_addr && lat == 1) chk("second_addr", addr, 32'h00F00004);
      if (repulse && lat == 1000) start = 1'b1;
      if (repulse && lat == 1001) start = 1'b0;
      if (abort_at > 0 && lat == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(done), 32'h1);
  endtask

  int lat, bcnt, d1, d2, nd;

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    fill(9'h000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_mask", 32'(key_mask), 32'h0);

    launch(1'b1, 1'b0, 1'b0, 0, lat, bcnt);
    chk("zero_latency", 32'(lat), 32'(N + 1));
    chk("zero_mask", 32'(key_mask), 32'h00);

    fill(9'h1FF);
    launch(1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    chk("ones_latency", 32'(lat), 32'(N + 1));
    chk("ones_busy_cycles", 32'(bcnt), 32'(N + 1));
    chk("ones_mask", 32'(key_mask), 32'hFF);

    fill(9'h000);
    fill_strip(3, 9'h049);
    launch(1'b0, 1'b1, 1'b0, 0, lat, bcnt);
    chk("strip3_thr3_mask", 32'(key_mask3), 32'h08);
    chk("strip3_thr9_mask", 32'(key_mask), 32'h00);

    fill(9'h000);
    fill_strip(4, 9'h1FF);
    fill_strip(6, 9'h1FF);
    for (int i = 0; i < 119; i++) mem[RS + i / KW][5 * KW + i % KW] = 9'h1FF;
    launch(1'b0, 1'b0, 1'b1, 0, lat, bcnt);
    chk("hits119_latency", 32'(lat), 32'(N + 1));
    chk("hits119_mask", 32'(key_mask), 32'h50);

    mem[RS + 119 / KW][5 * KW + 119 % KW] = 9'h1FF;
    launch(1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    chk("hits120_mask", 32'(key_mask), 32'h70);

    @(negedge clk);
    start = 1'b1;
    lat = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && lat < 3 * N) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = lat;
        else begin d2 = lat; start = 1'b0; end
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'(N + 2));
    chk("b2b_period", 32'(d2 - d1), 32'(N + 2));

    launch(1'b0, 1'b0, 1'b0, 2000, lat, bcnt);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_addr", addr, 32'h0);
    chk("abort_mask", 32'(key_mask), 32'h0);
    nd = 0;
    for (int i = 0; i < N + 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'h0);

    fill(9'h1FF);
    launch(1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    chk("restart_latency", 32'(lat), 32'(N + 1));
    chk("restart_mask", 32'(key_mask), 32'hFF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_scanner.md
# key_scanner

Downstream consumer of the camera canvas: reads the 160x120, 9-bit-per-pixel downsampled frame buffer through its registered read port (one-cycle latency) and decides which piano keys are covered by a finger. The canvas width is split into `NUM_KEYS` equal column strips over a fixed row band. For each strip the block counts the pixels whose brightness reaches a threshold and publishes a one-bit-per-key pressed mask once per scan. It sits between the camera canvas and the note/sound logic.

## Interface
- `NUM_KEYS`, 8: number of key strips; `NUM_KEYS*KEY_W` <= 160.
- `KEY_W`, 20: columns per strip; strip k covers cols `k*KEY_W .. k*KEY_W+KEY_W-1`.
- `ROW_START`, 60: first canvas row of the band (0..119).
- `ROW_END`, 89: last canvas row of the band, inclusive; >= `ROW_START`.
- `PIX_THRESH`, 9: a pixel is a hit when its field sum is >= this value (0..21).
- `HIT_MIN`, 120: a key is pressed when its hit count is >= this value.
- `CNT_W`, 12: hit counter width; must hold `KEY_W*(ROW_END-ROW_START+1)`.
- `mem_clk`, in, 1: the only clock; the canvas read port shares it.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request one scan; sampled only in IDLE.
- `addr`, out, 32: canvas read address; row in [24:18], col in [9:2], all other bits 0.
- `q`, in, 9: canvas read data, valid on the cycle after `addr`; fields [8:6], [5:3], [2:0].
- `busy`, out, 1: high from the start-accept edge until `done`.
- `done`, out, 1: one-cycle pulse; `key_mask` is updated on the same edge.
- `key_mask`, out, `NUM_KEYS`: bit k = strip k pressed; holds its value between scans.

## Operation
- States: IDLE, SCAN, DRAIN.
  - IDLE to SCAN when `start` is high.
  - SCAN to DRAIN after the address of the last pixel is issued.
  - DRAIN to IDLE on the edge that sets `done`.
- Scan order is key-major: for k = 0..NUM_KEYS-1, then row = ROW_START..ROW_END, then col across strip k. One address per cycle, no gaps.
- N = `NUM_KEYS*KEY_W*(ROW_END-ROW_START+1)` addresses per scan (default 4800).
- Classification:
  - Hit = (q[8:6] + q[5:3] + q[2:0]) >= `PIX_THRESH`.
  - The sum is computed 5 bits wide (max 21).
- Accumulation:
  - One `CNT_W` counter.
  - On the last pixel of a strip: `stage_mask[k] <= (cnt + hit) >= HIT_MIN`, then the counter clears.
  - Otherwise: `cnt <= cnt + hit`.
- A tag pipeline (valid, last-of-key, key index) follows each address by two stages to line up with `q`.
- `key_mask <= stage_mask` atomically, with the final bit merged in, on the `done` edge. Partial results are never visible.
- `start` while busy is ignored; there is no queuing.
- The canvas is written asynchronously by the camera. Tearing within a scan is accepted.
- Reset, including mid-scan, gives:
  - state IDLE, `busy`=0, `done`=0, `addr`=0, `key_mask`=0;
  - counter, stage mask and tags cleared.
  - No `done` is produced for an aborted scan.

## Timing
- `addr` is registered. On the edge E0 that accepts `start`: `busy`<=1 and `addr`<=pixel 0. After edge E_i, `addr` = pixel i, for i < N.
- `q` for pixel i is present after E_{i+1}; it is accumulated at E_{i+2}.
- `done`=1 and the final `key_mask` appear after E_{N+1}. `busy` falls on the same edge.
- Back-to-back: `start` held high re-launches on the edge after `done`. The period is N+2 cycles.
- Reset values: `busy` 0, `done` 0, `addr` 32'h0, `key_mask` 0.

## Structure
- Shared package `capiano_cam_pkg` holds:
  - canvas constants: `CANVAS_COLS`=160, `CANVAS_ROWS`=120;
  - address field positions: `ROW_LSB`=18, `ROW_W`=7, `COL_LSB`=2, `COL_W`=8;
  - pixel width 9 and field width 3.
  - These are shared with the canvas writer.
- One sub-module, `pixel_hit`: combinational field sum and compare. Inputs `q` and threshold; output the hit bit.
- The FSM, address generator, tag pipeline and accumulator stay in `key_scanner`.

## Test plan
- All-zero canvas, `start` pulse -> addresses follow scan order (first 0x00F00000, second 0x00F00004); `done` exactly N+1 cycles after acceptance; `key_mask`=8'h00.
- All-0x1FF canvas -> `key_mask`=8'hFF; `busy` high for exactly N+1 cycles.
- Strip 3 band filled with 0x049 (sum 3) and `PIX_THRESH`=3, rest zero -> `key_mask`=8'h08.
- Strip 5 with exactly 119 hits -> bit 5 = 0; with exactly 120 hits -> bit 5 = 1. Neighbouring strips are unaffected.
- `start` re-pulsed mid-scan -> ignored: a single `done`, timing unchanged.
- `rst` asserted at cycle 2000 of a scan -> next cycle all outputs at reset values, no `done`. A fresh `start` then completes normally.
